// File: rtl/ycbcr_rgb_pkg.sv
// Shared ISP constants for the YCbCr <-> RGB colour-space stages.
// Coefficients are x256 fixed point; the +128 rounding term is already
// folded into the offsets. PIPE_DEPTH is shared with the RGB-to-YCbCr stage.
package ycbcr_rgb_pkg;

  localparam int PIPE_DEPTH = 3;

  localparam logic [16:0] K_R_CR = 17'd359;
  localparam logic [16:0] K_G_CB = 17'd88;
  localparam logic [16:0] K_G_CR = 17'd183;
  localparam logic [16:0] K_B_CB = 17'd454;

  localparam logic signed [19:0] OFF_R = -20'sd45824;
  localparam logic signed [19:0] OFF_G =  20'sd34816;
  localparam logic signed [19:0] OFF_B = -20'sd57984;

  // Stage-1 registered products, all unsigned 17 bit.
  typedef struct packed {
    logic [16:0] y256;
    logic [16:0] r_cr;
    logic [16:0] g_cb;
    logic [16:0] g_cr;
    logic [16:0] b_cb;
  } prod_t;

  // Zero-extend an unsigned product into the signed 20-bit sum domain.
  function automatic logic signed [19:0] ext17(input logic [16:0] v);
    return $signed({3'b000, v});
  endfunction

endpackage

// File: rtl/ycbcr_rgb_sat_u8.sv
// sat_u8: combinational clamp of a signed 20-bit value to 8-bit unsigned.
//   din  : signed input (already scaled down by 256)
//   dout : 0 if din < 0, 255 if din > 255, else din[7:0]
module sat_u8 (
  input  logic signed [19:0] din,
  output logic [7:0]         dout
);

  always_comb begin
    dout = din[7:0];
    if (din[19])         dout = 8'h00;
    else if (|din[18:8]) dout = 8'hFF;
  end

endmodule

// File: rtl/ycbcr_rgb.sv
// ycbcr_rgb: 3-stage pipelined YCbCr 4:4:4 to RGB888/RGB565 converter.
//   sys_clk, sys_rst_n          : clock, async active-low reset
//   pre_wr_en/href/vsync        : input pixel valid and frame markers
//   img_y, img_cb, img_cr       : 8-bit pixel (chroma offset by 128)
//   post_wr_en/href/vsync       : markers delayed by PIPE_DEPTH cycles
//   rgb_r/g/b, rgb565_data      : result, forced to 0 when post_wr_en=0
// The datapath free-runs every cycle; only the output is gated by valid.
module ycbcr_rgb
  import ycbcr_rgb_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pre_wr_en,
  input  logic [7:0]  img_y,
  input  logic [7:0]  img_cb,
  input  logic [7:0]  img_cr,
  input  logic        pre_href,
  input  logic        pre_vsync,
  output logic        post_wr_en,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic [15:0] rgb565_data,
  output logic        post_href,
  output logic        post_vsync
);

  prod_t              prod;
  logic signed [19:0] sum_r, sum_g, sum_b;
  logic signed [19:0] sh_r, sh_g, sh_b;
  logic [7:0]         sat_r, sat_g, sat_b;
  logic [7:0]         r_q, g_q, b_q;

  logic [PIPE_DEPTH:1] vld_pipe, href_pipe, vs_pipe;

  // Stage 1: products
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prod <= '0;
    end else begin
      prod.y256 <= {1'b0, img_y, 8'h00};
      prod.r_cr <= 17'(img_cr) * K_R_CR;
      prod.g_cb <= 17'(img_cb) * K_G_CB;
      prod.g_cr <= 17'(img_cr) * K_G_CR;
      prod.b_cb <= 17'(img_cb) * K_B_CB;
    end
  end

  // Stage 2: signed sums; the full range fits comfortably in 20 bits
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sum_r <= '0;
      sum_g <= '0;
      sum_b <= '0;
    end else begin
      sum_r <= ext17(prod.y256) + ext17(prod.r_cr) + OFF_R;
      sum_g <= ext17(prod.y256) - ext17(prod.g_cb) - ext17(prod.g_cr) + OFF_G;
      sum_b <= ext17(prod.y256) + ext17(prod.b_cb) + OFF_B;
    end
  end

  // Stage 3: arithmetic shift (floor divide by 256) then clamp
  assign sh_r = sum_r >>> 8;
  assign sh_g = sum_g >>> 8;
  assign sh_b = sum_b >>> 8;

  sat_u8 u_sat_r (.din(sh_r), .dout(sat_r));
  sat_u8 u_sat_g (.din(sh_g), .dout(sat_g));
  sat_u8 u_sat_b (.din(sh_b), .dout(sat_b));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= sat_r;
      g_q <= sat_g;
      b_q <= sat_b;
    end
  end

  // Marker delay lines; bit k holds the marker k cycles late
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe  <= '0;
      href_pipe <= '0;
      vs_pipe   <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[PIPE_DEPTH-1:1],  pre_wr_en};
      href_pipe <= {href_pipe[PIPE_DEPTH-1:1], pre_href};
      vs_pipe   <= {vs_pipe[PIPE_DEPTH-1:1],   pre_vsync};
    end
  end

  assign post_wr_en = vld_pipe[PIPE_DEPTH];
  assign post_href  = href_pipe[PIPE_DEPTH];
  assign post_vsync = vs_pipe[PIPE_DEPTH];

  // Gate from the same register that drives post_wr_en: no skew possible
  assign rgb_r       = post_wr_en ? r_q : 8'h00;
  assign rgb_g       = post_wr_en ? g_q : 8'h00;
  assign rgb_b       = post_wr_en ? b_q : 8'h00;
  assign rgb565_data = post_wr_en ? {r_q[7:3], g_q[7:2], b_q[7:3]} : 16'h0000;

endmodule

// File: tb/tb_ycbcr_rgb.sv
module tb_ycbcr_rgb;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        pre_wr_en, pre_href, pre_vsync;
  logic [7:0]  img_y, img_cb, img_cr;
  logic        post_wr_en, post_href, post_vsync;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic [15:0] rgb565_data;

  ycbcr_rgb dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pre_wr_en(pre_wr_en), .img_y(img_y), .img_cb(img_cb), .img_cr(img_cr),
    .pre_href(pre_href), .pre_vsync(pre_vsync),
    .post_wr_en(post_wr_en), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .rgb565_data(rgb565_data), .post_href(post_href), .post_vsync(post_vsync)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        wr, href, vs;
    logic [7:0]  r, g, b;
    logic [15:0] p565;
  } out_t;

  typedef struct {
    logic        wr, href, vs;
    logic [7:0]  y, cb, cr;
    logic [7:0]  er, eg, eb;
    logic [15:0] e565;
  } vec_t;

  int   nvec = 0;
  int   nerr = 0;
  out_t q[$];

  function automatic out_t sample();
    return {post_wr_en, post_href, post_vsync, rgb_r, rgb_g, rgb_b, rgb565_data};
  endfunction

  function automatic logic [7:0] clamp(input int v);
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  // Reference straight from the conversion formulas
  function automatic out_t model(input logic wr, hr, vs, input logic [7:0] y, cb, cr);
    int yi, cbi, cri;
    out_t o;
    yi = int'(y); cbi = int'(cb); cri = int'(cr);
    o.wr = wr; o.href = hr; o.vs = vs;
    o.r = wr ? clamp((256*yi + 359*cri - 45824) >>> 8) : 8'd0;
    o.g = wr ? clamp((256*yi - 88*cbi - 183*cri + 34816) >>> 8) : 8'd0;
    o.b = wr ? clamp((256*yi + 454*cbi - 57984) >>> 8) : 8'd0;
    o.p565 = {o.r[7:3], o.g[7:2], o.b[7:3]};
    return o;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got wr/href/vs=%b%b%b rgb=%02h_%02h_%02h 565=%04h, want wr/href/vs=%b%b%b rgb=%02h_%02h_%02h 565=%04h",
               name, $time, act.wr, act.href, act.vs, act.r, act.g, act.b, act.p565,
               exp.wr, exp.href, exp.vs, exp.r, exp.g, exp.b, exp.p565);
    end
  endtask

  task automatic drive(input logic wr, hr, vs, input logic [7:0] y, cb, cr);
    pre_wr_en = wr; pre_href = hr; pre_vsync = vs;
    img_y = y; img_cb = cb; img_cr = cr;
  endtask

  // One clock: check output against the input driven 3 cycles earlier,
  // drive the next input, advance to just after the next rising edge.
  task automatic cycle(input string name, input logic wr, hr, vs, input logic [7:0] y, cb, cr);
    if (q.size() >= 3) chk(name, sample(), q.pop_front());
    drive(wr, hr, vs, y, cb, cr);
    q.push_back(model(wr, hr, vs, y, cb, cr));
    @(posedge sys_clk); #1;
  endtask

  task automatic prefill_idle();
    q.delete();
    repeat (3) q.push_back('0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 16'h8410};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255, 16'hFD3F};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0,   16'h0440};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'd200, 8'd50,  8'd60,  8'd0,   8'd0,   8'd0,   16'h0000};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0,   16'hF800};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 8'd128, 8'd255, 8'd128, 8'd128, 8'd84,  8'd255, 16'h82BF};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'd16,  8'd128, 8'd128, 8'd16,  8'd16,  8'd16,  16'h1082};

    // Power-on reset with busy inputs: everything must read 0
    sys_rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'd200, 8'd100, 8'd250);
    #2 chk("reset_async", sample(), '0);
    repeat (3) @(posedge sys_clk);
    #1 chk("reset_held", sample(), '0);
    sys_rst_n = 1'b1;

    // Directed table, streamed back to back
    for (int i = 0; i < 7 + 3; i++) begin
      if (i >= 3)
        chk($sformatf("vec%0d", i - 3), sample(),
            {tbl[i-3].wr, tbl[i-3].href, tbl[i-3].vs, tbl[i-3].er, tbl[i-3].eg, tbl[i-3].eb, tbl[i-3].e565});
      else
        chk("post_reset_zero", sample(), '0);
      if (i < 7) drive(tbl[i].wr, tbl[i].href, tbl[i].vs, tbl[i].y, tbl[i].cb, tbl[i].cr);
      else       drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      @(posedge sys_clk); #1;
    end

    // Isolated pixel: output appears on exactly the 3rd edge
    drive(1'b1, 1'b0, 1'b0, 8'd76, 8'd85, 8'd255);
    @(posedge sys_clk); #1;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("iso_lat1", sample(), '0);
    @(posedge sys_clk); #1;
    chk("iso_lat2", sample(), '0);
    @(posedge sys_clk); #1;
    chk("iso_lat3", sample(), {1'b1, 1'b0, 1'b0, 8'd254, 8'd0, 8'd0, 16'hF800});
    @(posedge sys_clk); #1;
    chk("iso_lat4", sample(), '0);
    repeat (2) begin @(posedge sys_clk); #1; end
    prefill_idle();

    // Framing: 1-cycle vsync, then a 640-pixel line with random bubbles
    repeat (3) cycle("frame_idle", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    cycle("frame_vs", 1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 8'd9);
    repeat (4) cycle("frame_idle", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int px = 0; px < 640; px++) begin
      if (px > 0 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3))
          cycle("frame_bubble", 1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      cycle("frame_px", 1'b1, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    repeat (6) cycle("frame_tail", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // Reset mid-line: in-flight pixels are lost
    repeat (5) cycle("burst", 1'b1, 1'b1, 1'b0, 8'd128, 8'd128, 8'd128);
    sys_rst_n = 1'b0;
    #1 chk("midreset_async", sample(), '0);
    @(posedge sys_clk); #1;
    chk("midreset_hold1", sample(), '0);
    @(posedge sys_clk); #1;
    chk("midreset_hold2", sample(), '0);
    sys_rst_n = 1'b1;
    prefill_idle();
    repeat (6) cycle("after_reset", 1'b1, 1'b1, 1'b0, 8'd128, 8'd128, 8'd128);
    repeat (4) cycle("drain", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary (got running, want finished)");
    $fatal(1);
  end

endmodule
